// File: rtl/cordic_pkg.sv
// Shared constants and state type for the vectoring CORDIC.
// Tables are stored at 20 fractional bits and shifted down for narrower builds.
package cordic_pkg;

  localparam int LUT_FRAC  = 20;
  localparam int LUT_DEPTH = 20;
  localparam int LUT_W     = LUT_FRAC + 3;

  // atan(2^-i) in Q3.20, rounded to nearest
  localparam logic [LUT_W-1:0] ATAN_LUT [LUT_DEPTH] = '{
    23'd823550, 23'd486170, 23'd256879, 23'd130396, 23'd65451,
    23'd32757,  23'd16383,  23'd8192,   23'd4096,   23'd2048,
    23'd1024,   23'd512,    23'd256,    23'd128,    23'd64,
    23'd32,     23'd16,     23'd8,      23'd4,      23'd2
  };

  localparam logic [LUT_W-1:0]    PI_HALF  = 23'h1921FB;
  localparam logic [LUT_FRAC-1:0] CORDIC_K = 20'd636751;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } cordic_vec_state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: drives y toward zero, accumulating the applied angle in z.
module cordic_vec_step #(
  parameter int XW = 24,
  parameter int ZW = 23,
  parameter int SW = 5
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic signed [ZW-1:0] atan_i,
  input  logic        [SW-1:0] shift_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (!y_i[XW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vector_seq.sv
// Iterative vectoring CORDIC returning magnitude and atan2(y,x); FRAC_BITS up to 20.
// Define GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain from the magnitude.
module cordic_vector_seq
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS  = 20,
  parameter int ITERATIONS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAC_BITS+1:0] x_in,
  input  logic [FRAC_BITS+1:0] y_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_BITS+2:0] mag_out,
  output logic [FRAC_BITS+2:0] ang_out
);

  localparam int W         = FRAC_BITS + 2;
  localparam int XW        = W + 2;
  localparam int ZW        = W + 1;
  localparam int CW        = $clog2(FRAC_BITS + 1);
  localparam int LUT_SHIFT = LUT_FRAC - FRAC_BITS;
  localparam logic [CW-1:0]        LAST_STEP = CW'(ITERATIONS - 1);
  localparam logic signed [ZW-1:0] PI_HALF_Z = ZW'(PI_HALF >> LUT_SHIFT);

  cordic_vec_state_t state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic [ZW-1:0]        mag_q, mag_d, ang_q, ang_d;

  logic signed [XW-1:0] x_ext, y_ext;
  logic [LUT_W-1:0]     atan_raw;
  logic signed [ZW-1:0] atan_z;
  logic signed [XW-1:0] step_x, step_y;
  logic signed [ZW-1:0] step_z;

  assign x_ext    = {{2{x_in[W-1]}}, x_in};
  assign y_ext    = {{2{y_in[W-1]}}, y_in};
  assign atan_raw = ATAN_LUT[cnt_q] >> LUT_SHIFT;
  assign atan_z   = atan_raw[ZW-1:0];

  cordic_vec_step #(
    .XW(XW),
    .ZW(ZW),
    .SW(CW)
  ) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .atan_i (atan_z),
    .shift_i(cnt_q),
    .x_o    (step_x),
    .y_o    (step_y),
    .z_o    (step_z)
  );

`ifdef GAIN_COMP_EN
  localparam int PW = XW + FRAC_BITS + 1;
  localparam logic [FRAC_BITS-1:0] K_Q = FRAC_BITS'(CORDIC_K >> LUT_SHIFT);

  logic signed [PW-1:0] mul_x, mul_k, mul_p;
  logic signed [XW-1:0] x_scaled;

  // x is non-negative after iteration, so dropping the low bits is a floor
  assign mul_x    = PW'(x_q);
  assign mul_k    = PW'($signed({1'b0, K_Q}));
  assign mul_p    = mul_x * mul_k;
  assign x_scaled = mul_p[FRAC_BITS +: XW];
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    mag_d     = mag_q;
    ang_d     = ang_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_ITER;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          // Fold the vector into the right half-plane; (-1,0) takes the +pi/2 branch so it yields +pi
          if (!x_in[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_in[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = PI_HALF_Z;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -PI_HALF_Z;
          end
        end
      end

      ST_ITER: begin
        x_d   = step_x;
        y_d   = step_y;
        z_d   = step_z;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d = '0;
`ifdef GAIN_COMP_EN
          state_d = ST_SCALE;
`else
          state_d = ST_DONE;
          mag_d   = zero_q ? '0 : step_x[ZW-1:0];
          ang_d   = zero_q ? '0 : step_z;
`endif
        end
      end

`ifdef GAIN_COMP_EN
      ST_SCALE: begin
        x_d     = x_scaled;
        mag_d   = zero_q ? '0 : x_scaled[ZW-1:0];
        ang_d   = zero_q ? '0 : z_q;
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign mag_out = mag_q;
  assign ang_out = ang_q;

endmodule
